// File: rtl/tour_pkg.sv
// tour_pkg -- shared definitions for the knight's-tour command sequencer.
//   tour_state_e : sequencer FSM states
//   MOVE / MOVE_FANFARE : command opcodes for the vertical / horizontal leg
//   HDG_* : heading codes understood by the command processor
//   RESP_* : response bytes returned to the UART wrapper
//   mk_cmd : packs {opcode, heading, squares} into a 16-bit command
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_ISSUE = 3'd1,
    V_WAIT  = 3'd2,
    H_ISSUE = 3'd3,
    H_WAIT  = 3'd4
  } tour_state_e;

  localparam logic [3:0] MOVE         = 4'h2;
  localparam logic [3:0] MOVE_FANFARE = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam logic [7:0] RESP_IDLE = 8'hA5;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_move_dec.sv
// tour_move_dec -- combinational decode of a one-hot knight move into the
// two commands that realise it: a vertical leg followed by a horizontal leg.
// If several bits are set the lowest one wins.
//   i_move  : one-hot knight move (bit0..bit7)
//   o_v_cmd : vertical-leg command   {MOVE, heading, squares}
//   o_h_cmd : horizontal-leg command {MOVE_FANFARE, heading, squares}
//   o_valid : at least one move bit set
module tour_move_dec
  import tour_pkg::*;
(
  input  logic [7:0]  i_move,
  output logic [15:0] o_v_cmd,
  output logic [15:0] o_h_cmd,
  output logic        o_valid
);

  logic [7:0] w_v_hdg;
  logic [3:0] w_v_sq;
  logic [7:0] w_h_hdg;
  logic [3:0] w_h_sq;

  always_comb begin
    w_v_hdg = HDG_N;
    w_v_sq  = 4'd0;
    w_h_hdg = HDG_W;
    w_h_sq  = 4'd0;
    if (i_move[0]) begin          // N2 W1
      w_v_hdg = HDG_N; w_v_sq = 4'd2; w_h_hdg = HDG_W; w_h_sq = 4'd1;
    end else if (i_move[1]) begin // N2 E1
      w_v_hdg = HDG_N; w_v_sq = 4'd2; w_h_hdg = HDG_E; w_h_sq = 4'd1;
    end else if (i_move[2]) begin // N1 W2
      w_v_hdg = HDG_N; w_v_sq = 4'd1; w_h_hdg = HDG_W; w_h_sq = 4'd2;
    end else if (i_move[3]) begin // S1 W2
      w_v_hdg = HDG_S; w_v_sq = 4'd1; w_h_hdg = HDG_W; w_h_sq = 4'd2;
    end else if (i_move[4]) begin // S2 W1
      w_v_hdg = HDG_S; w_v_sq = 4'd2; w_h_hdg = HDG_W; w_h_sq = 4'd1;
    end else if (i_move[5]) begin // S2 E1
      w_v_hdg = HDG_S; w_v_sq = 4'd2; w_h_hdg = HDG_E; w_h_sq = 4'd1;
    end else if (i_move[6]) begin // S1 E2
      w_v_hdg = HDG_S; w_v_sq = 4'd1; w_h_hdg = HDG_E; w_h_sq = 4'd2;
    end else if (i_move[7]) begin // N1 E2
      w_v_hdg = HDG_N; w_v_sq = 4'd1; w_h_hdg = HDG_E; w_h_sq = 4'd2;
    end
  end

  assign o_v_cmd = mk_cmd(MOVE, w_v_hdg, w_v_sq);
  assign o_h_cmd = mk_cmd(MOVE_FANFARE, w_h_hdg, w_h_sq);
  assign o_valid = |i_move;

endmodule

// File: rtl/tour_cmd.sv
// tour_cmd -- sequences a knight's tour into command-processor commands.
// In IDLE the UART command path is passed straight through. A start_tour
// pulse walks mv_indx from 0 to LAST_MOVE; each move becomes a vertical leg
// and then a horizontal leg, each issued and acknowledged in turn.
//
// Handshake: cmd is offered while cmd_rdy=1 and held stable; the command
// processor takes it by pulsing clr_cmd_rdy, and later reports completion
// with send_resp. clr_cmd_rdy while not offering and send_resp while
// offering are ignored.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_tour        : pulse, begins a tour (IDLE only)
//   move              : one-hot move for mv_indx from the solver memory
//   mv_indx           : index of the move being issued
//   cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART : UART wrapper command path
//   cmd, cmd_rdy, clr_cmd_rdy, send_resp     : command processor path
//   resp              : 8'h5A while a tour runs, 8'hA5 otherwise
//   dbg_state         : current FSM state, for observation only
module tour_cmd
  import tour_pkg::*;
#(
  parameter int LAST_MOVE = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic [2:0]  dbg_state
);

  localparam logic [4:0] LAST_IDX = 5'(LAST_MOVE);

  tour_state_e r_state;
  tour_state_e w_state_nxt;
  logic [4:0]  r_mv_indx;
  logic [4:0]  w_mv_indx_nxt;
  logic [15:0] w_v_cmd;
  logic [15:0] w_h_cmd;
  logic        w_move_valid;

  tour_move_dec u_dec (
    .i_move  (move),
    .o_v_cmd (w_v_cmd),
    .o_h_cmd (w_h_cmd),
    .o_valid (w_move_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mv_indx <= w_mv_indx_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mv_indx_nxt    = r_mv_indx;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;
    unique case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_IDLE;
        if (start_tour) begin
          w_state_nxt   = V_ISSUE;
          w_mv_indx_nxt = 5'd0;
        end
      end
      V_ISSUE: begin
        cmd = w_v_cmd;
        // An empty move means the solver has nothing for us: abandon quietly.
        if (!w_move_valid) begin
          w_state_nxt = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) w_state_nxt = V_WAIT;
        end
      end
      V_WAIT: begin
        cmd = w_v_cmd;
        if (send_resp) w_state_nxt = H_ISSUE;
      end
      H_ISSUE: begin
        cmd     = w_h_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) w_state_nxt = H_WAIT;
      end
      H_WAIT: begin
        cmd = w_h_cmd;
        if (send_resp) begin
          if (r_mv_indx >= LAST_IDX) begin
            // The final completion already reports the tour as finished.
            w_state_nxt = IDLE;
            resp        = RESP_IDLE;
          end else begin
            w_state_nxt   = V_ISSUE;
            w_mv_indx_nxt = r_mv_indx + 5'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mv_indx   = r_mv_indx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;
  import tour_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  // ---------------- solver memory model ----------------
  logic [7:0]  tour_mem [0:23];
  int          low_bit  [0:23];
  logic [15:0] v_tab    [0:7];
  logic [15:0] h_tab    [0:7];

  assign move = (mv_indx <= 5'd23) ? tour_mem[mv_indx] : 8'h00;

  tour_cmd #(.LAST_MOVE(23)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drives and checks happen around the falling edge.
  task automatic wait_rdy(input string tag);
    int w;
    w = 0;
    while (cmd_rdy !== 1'b1 && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    if (cmd_rdy !== 1'b1) chk({tag, "_rdy_timeout"}, {15'd0, cmd_rdy}, 16'd1);
  endtask

  task automatic take_cmd(input string tag);
    logic [15:0] e;
    wait_rdy(tag);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, "_cmd"}, cmd, e);
    chk({tag, "_resp_busy"}, {8'd0, resp}, {8'd0, RESP_BUSY});
    clr_cmd_rdy = 1'b1;
    #1;
    chk({tag, "_clr_uart_blocked"}, {15'd0, clr_cmd_rdy_UART}, 16'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
    chk({tag, "_rdy_dropped"}, {15'd0, cmd_rdy}, 16'd0);
  endtask

  task automatic finish_leg(input string tag, input bit last);
    send_resp = 1'b1;
    #1;
    if (last) chk({tag, "_final_resp"}, {8'd0, resp}, {8'd0, RESP_IDLE});
    @(negedge clk);
    send_resp = 1'b0;
    #1;
  endtask

  task automatic run_move(input int i, input bit probe);
    logic [4:0] saved;
    string t;
    t = $sformatf("mv%0d", i);
    exp_q.push_back(v_tab[low_bit[i]]);
    exp_q.push_back(h_tab[low_bit[i]]);
    chk({t, "_indx"}, {11'd0, mv_indx}, 16'(i));
    if (probe) begin
      // completion while offering must not advance the FSM
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      #1;
      chk({t, "_sresp_in_issue"}, {13'd0, dbg_state}, 16'(V_ISSUE));
    end
    take_cmd({t, "_v"});
    if (probe) begin
      saved = mv_indx;
      start_tour   = 1'b1;
      clr_cmd_rdy  = 1'b1;
      #1;
      chk({t, "_vwait_rdy"}, {15'd0, cmd_rdy}, 16'd0);
      chk({t, "_vwait_clr_uart"}, {15'd0, clr_cmd_rdy_UART}, 16'd0);
      @(negedge clk);
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
      #1;
      chk({t, "_vwait_state"}, {13'd0, dbg_state}, 16'(V_WAIT));
      chk({t, "_vwait_indx"}, {11'd0, mv_indx}, {11'd0, saved});
    end
    finish_leg({t, "_v"}, 1'b0);
    take_cmd({t, "_h"});
    finish_leg({t, "_h"}, i == 23);
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    v_tab = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    h_tab = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};
    tour_mem = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h40, 8'h20, 8'h80,
                 8'h06, 8'hC8, 8'hFF, 8'h30, 8'hA0, 8'h80, 8'h44, 8'h0C,
                 8'h60, 8'h18, 8'h81, 8'hC0, 8'h12, 8'h90, 8'h40, 8'h01};
    low_bit  = '{0, 1, 2, 3, 4, 6, 5, 7,
                 1, 3, 0, 4, 5, 7, 2, 2,
                 5, 3, 0, 6, 1, 4, 6, 0};

    // reset state
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {13'd0, dbg_state}, 16'(IDLE));
    chk("rst_indx", {11'd0, mv_indx}, 16'd0);
    chk("rst_resp", {8'd0, resp}, 16'h00A5);
    chk("rst_rdy_pass", {15'd0, cmd_rdy}, 16'd1);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // IDLE pass-through
    cmd_UART = 16'h2002;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b1;
    #1;
    chk("idle_cmd", cmd, 16'h2002);
    chk("idle_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("idle_clr_pass", {15'd0, clr_cmd_rdy_UART}, 16'd1);
    chk("idle_resp", {8'd0, resp}, 16'h00A5);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("idle_clr_low", {15'd0, clr_cmd_rdy_UART}, 16'd0);
    chk("idle_rdy_low", {15'd0, cmd_rdy}, 16'd0);

    // full tour; UART holds a pending command throughout and must be ignored
    cmd_UART = 16'hDEAD;
    cmd_rdy_UART = 1'b1;
    pulse_start();
    chk("start_state", {13'd0, dbg_state}, 16'(V_ISSUE));
    chk("start_latency_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("start_cmd", cmd, 16'h2002);
    for (int i = 0; i < 24; i++) begin
      run_move(i, i == 2);
      if (i == 0) begin
        chk("after_mv0_indx", {11'd0, mv_indx}, 16'd1);
        chk("after_mv0_resp", {8'd0, resp}, 16'h005A);
      end
    end
    chk("tour_end_state", {13'd0, dbg_state}, 16'(IDLE));
    chk("tour_end_indx", {11'd0, mv_indx}, 16'd23);
    chk("tour_end_resp", {8'd0, resp}, 16'h00A5);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    #1;
    chk("extra_sresp_state", {13'd0, dbg_state}, 16'(IDLE));
    chk("extra_sresp_indx", {11'd0, mv_indx}, 16'd23);
    chk("extra_sresp_queue", 16'(exp_q.size()), 16'd0);

    // reset mid-tour in H_WAIT at move 7
    cmd_rdy_UART = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) run_move(i, 1'b0);
    exp_q.push_back(v_tab[low_bit[7]]);
    exp_q.push_back(h_tab[low_bit[7]]);
    take_cmd("rst7_v");
    finish_leg("rst7_v", 1'b0);
    take_cmd("rst7_h");
    chk("rst7_pre_state", {13'd0, dbg_state}, 16'(H_WAIT));
    chk("rst7_pre_indx", {11'd0, mv_indx}, 16'd7);
    #3 rst_n = 1'b0;
    #1;
    chk("rst7_state", {13'd0, dbg_state}, 16'(IDLE));
    chk("rst7_indx", {11'd0, mv_indx}, 16'd0);
    chk("rst7_resp", {8'd0, resp}, 16'h00A5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst7_no_cmd", {15'd0, cmd_rdy}, 16'd0);
    end
    exp_q.delete();

    // empty move aborts the tour without offering a command
    tour_mem[0] = 8'h00;
    pulse_start();
    chk("zero_issue_state", {13'd0, dbg_state}, 16'(V_ISSUE));
    chk("zero_issue_rdy", {15'd0, cmd_rdy}, 16'd0);
    @(negedge clk); #1;
    chk("zero_abort_state", {13'd0, dbg_state}, 16'(IDLE));
    chk("zero_abort_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("zero_abort_resp", {8'd0, resp}, 16'h00A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter LAST_MOVE, default 23, index of final move in the tour list.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start_tour  input  1  single-cycle pulse that begins a tour.
REQ-005 move  input  8  one-hot knight move for the current mv_indx, read combinationally from the tour solver memory.
REQ-006 mv_indx  output  5  index of the move currently being issued.
REQ-007 cmd_UART  input  16  command from the BLE/UART wrapper.
REQ-008 cmd_rdy_UART  input  1  UART command valid.
REQ-009 clr_cmd_rdy_UART  output  1  consume the UART command.
REQ-010 cmd  output  16  command to the command processor.
REQ-011 cmd_rdy  output  1  cmd valid.
REQ-012 clr_cmd_rdy  input  1  command processor consumed cmd.
REQ-013 send_resp  input  1  command processor finished the command.
REQ-014 resp  output  8  response byte to the UART wrapper.

Function
REQ-015 The FSM SHALL use states IDLE, V_ISSUE, V_WAIT, H_ISSUE and H_WAIT.
REQ-016 In IDLE, cmd SHALL equal cmd_UART, cmd_rdy SHALL equal cmd_rdy_UART, and clr_cmd_rdy_UART SHALL equal clr_cmd_rdy, as a combinational pass-through.
REQ-017 Outside IDLE, clr_cmd_rdy_UART SHALL be 0 and UART commands SHALL be ignored; they are not lost, because the wrapper holds them.
REQ-018 IDLE SHALL move to V_ISSUE on start_tour, and mv_indx SHALL clear to 0 in the same edge. start_tour has priority over a simultaneous cmd_rdy_UART.
REQ-019 Decode of each knight move into vertical then horizontal legs:
- bit0: N2 W1
- bit1: N2 E1
- bit2: N1 W2
- bit3: S1 W2
- bit4: S2 W1
- bit5: S2 E1
- bit6: S1 E2
- bit7: N1 E2
REQ-020 Heading codes SHALL be N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
REQ-021 Command format SHALL be {opcode[3:0], heading[7:0], squares[3:0]}.
- Vertical leg: opcode 4'h2.
- Horizontal leg: opcode 4'h3 (move with fanfare).
REQ-022 In V_ISSUE, cmd SHALL be the vertical-leg command and cmd_rdy SHALL be 1; the FSM SHALL move to V_WAIT on clr_cmd_rdy.
REQ-023 V_WAIT SHALL drive cmd_rdy 0 and SHALL move to H_ISSUE on send_resp.
REQ-024 H_ISSUE and H_WAIT SHALL mirror V_ISSUE and V_WAIT using the horizontal-leg command.
REQ-025 In H_WAIT on send_resp:
- if mv_indx==LAST_MOVE, go to IDLE with mv_indx held;
- otherwise increment mv_indx and go to V_ISSUE.
REQ-026 Latency: start_tour at edge n SHALL give cmd_rdy=1 after edge n; cmd SHALL be stable while cmd_rdy=1.
REQ-027 Decode SHALL be lowest-set-bit priority.
REQ-028 If move==8'h00 in V_ISSUE, the tour SHALL abort to IDLE on the next edge without asserting cmd_rdy.
REQ-029 start_tour outside IDLE SHALL be ignored.
REQ-030 send_resp in V_ISSUE or H_ISSUE SHALL be ignored.
REQ-031 clr_cmd_rdy in V_WAIT or H_WAIT SHALL be ignored.
REQ-032 resp SHALL be 8'h5A while a tour is in progress (any non-IDLE state), otherwise 8'hA5.
REQ-033 A send_resp in H_WAIT with mv_indx==LAST_MOVE SHALL see resp=8'hA5.
REQ-034 mv_indx SHALL never exceed LAST_MOVE and SHALL not wrap.

Reset
REQ-035 On rst_n low, asynchronously:
- state=IDLE;
- mv_indx=5'd0;
- resulting outputs: cmd_rdy follows cmd_rdy_UART, resp=8'hA5.
REQ-036 Reset mid-tour SHALL abandon the tour with no further commands issued.

Structure
REQ-037 The state enum, opcode constants (MOVE=4'h2, MOVE_FANFARE=4'h3) and heading constants SHALL live in shared package tour_pkg.
REQ-038 Move decode SHALL be a combinational sub-module, tour_move_dec: move in, vertical and horizontal commands out.
REQ-039 The top level SHALL contain only the FSM, the mv_indx counter and the mux.

Verification
REQ-040 In IDLE, cmd_UART=16'h2002 with cmd_rdy_UART=1 -> cmd=16'h2002, cmd_rdy=1, and clr_cmd_rdy pulse appears on clr_cmd_rdy_UART; resp=8'hA5.
REQ-041 start_tour with move=8'h01 -> cmd=16'h2002; after clr_cmd_rdy and send_resp -> cmd=16'h33F1; after send_resp -> mv_indx=1, resp=8'h5A.
REQ-042 move=8'h40 at mv_indx 5 -> cmd=16'h27F1, then 16'h3BF2.
REQ-043 Full tour with LAST_MOVE=23 and 48 handshakes -> IDLE, mv_indx=23, resp=8'hA5; a further send_resp causes no change.
REQ-044 During V_WAIT, pulse start_tour and assert cmd_rdy_UART -> cmd_rdy stays 0, clr_cmd_rdy_UART stays 0, mv_indx is unchanged.
REQ-045 Assert rst_n low in H_WAIT at mv_indx 7 -> IDLE, mv_indx=0 immediately; move=8'h00 at start_tour -> return to IDLE with no cmd_rdy.
